// File: rtl/pic_pkg.sv
// Shared definitions for the interrupt request controller: acknowledge FSM
// states and the index reported for a spurious acknowledge.
package pic_pkg;

  typedef enum logic [1:0] {
    ACK_IDLE = 2'd0,
    ACK_ONE  = 2'd1,
    ACK_TWO  = 2'd2
  } ack_state_e;

  // Spurious acknowledges report the last line of the controller.
  function automatic int spurious_index(input int num_irq);
    return num_irq - 1;
  endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// Rotating-priority resolver: picks the highest-priority request relative to
// base and accepts it only if it outranks every in-service bit.
module pic_priority_resolver #(
  parameter int NUM_IRQ = 8,
  localparam int IDX_W = $clog2(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] req,
  input  logic [NUM_IRQ-1:0] isr,
  input  logic [IDX_W-1:0]   base,
  output logic               valid,
  output logic [IDX_W-1:0]   index
);

  logic             req_hit_s;
  logic             isr_hit_s;
  logic [IDX_W-1:0] req_idx_s;
  logic [IDX_W:0]   req_rank_s;
  logic [IDX_W:0]   isr_rank_s;

  // Scan from lowest to highest rank so the last hit is the best one.
  always_comb begin
    logic [IDX_W:0] pos;
    req_hit_s  = 1'b0;
    isr_hit_s  = 1'b0;
    req_idx_s  = '0;
    req_rank_s = '0;
    isr_rank_s = '0;
    pos        = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      pos = {1'b0, base} + (IDX_W+1)'(k);
      if (pos >= (IDX_W+1)'(NUM_IRQ)) begin
        pos = pos - (IDX_W+1)'(NUM_IRQ);
      end else begin
        pos = pos;
      end
      if (req[pos[IDX_W-1:0]]) begin
        req_hit_s  = 1'b1;
        req_idx_s  = pos[IDX_W-1:0];
        req_rank_s = (IDX_W+1)'(k);
      end else begin
        req_hit_s  = req_hit_s;
      end
      if (isr[pos[IDX_W-1:0]]) begin
        isr_hit_s  = 1'b1;
        isr_rank_s = (IDX_W+1)'(k);
      end else begin
        isr_hit_s  = isr_hit_s;
      end
    end
  end

  assign valid = req_hit_s && (!isr_hit_s || (req_rank_s < isr_rank_s));
  assign index = req_idx_s;

endmodule

// File: rtl/irq_request_ctrl.sv
// Interrupt request controller: synchronised edge/level requests, fully nested
// in-service tracking and a two-pulse INTA handshake. PIC_ROTATE_EN enables
// rotating priority on end-of-interrupt.
module irq_request_ctrl
  import pic_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  localparam int IDX_W = $clog2(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_lines,
  input  logic [NUM_IRQ-1:0] trig_mode,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic               inta,
  input  logic               eoi,
  output logic               int_out,
  output logic [IDX_W-1:0]   vector_idx,
  output logic               vector_valid,
  output logic [NUM_IRQ-1:0] irr,
  output logic [NUM_IRQ-1:0] isr
);

  localparam logic [IDX_W-1:0]   SPURIOUS_IDX = IDX_W'(spurious_index(NUM_IRQ));
  localparam logic [NUM_IRQ-1:0] ONE_HOT_LSB  = {{(NUM_IRQ-1){1'b0}}, 1'b1};

  logic [NUM_IRQ-1:0] sync1_r, sync2_r, prev_r, edge_r, irr_r, isr_r;
  logic [NUM_IRQ-1:0] cand_s, win_mask_s, eoi_mask_s, isr_post_s, irr_next_s;
  logic               win_valid_s, eoi_hit_s, take_s;
  logic [IDX_W-1:0]   win_idx_s, eoi_idx_s, base_s, latch_idx_r, vector_idx_r;
  logic               int_out_r, vector_valid_r;
  ack_state_e         state_r, state_next_s;

  assign take_s     = (state_r == ACK_IDLE) && inta;
  assign cand_s     = irr_r & ~irq_mask;
  assign win_mask_s = (take_s && win_valid_s) ? (ONE_HOT_LSB << win_idx_s) : '0;
  assign eoi_mask_s = (eoi && eoi_hit_s) ? (ONE_HOT_LSB << eoi_idx_s) : '0;
  // The EOI is retired before the winner is judged against in-service bits.
  assign isr_post_s = isr_r & ~eoi_mask_s;
  assign irr_next_s = (((irr_r & ~win_mask_s) | edge_r) & ~trig_mode)
                    | (prev_r & ~win_mask_s & trig_mode);

  pic_priority_resolver #(.NUM_IRQ(NUM_IRQ)) u_win (
    .req(cand_s), .isr(isr_post_s), .base(base_s),
    .valid(win_valid_s), .index(win_idx_s)
  );

  pic_priority_resolver #(.NUM_IRQ(NUM_IRQ)) u_eoi (
    .req(isr_r), .isr({NUM_IRQ{1'b0}}), .base(base_s),
    .valid(eoi_hit_s), .index(eoi_idx_s)
  );

`ifdef PIC_ROTATE_EN
  logic [IDX_W-1:0] base_r;

  // Rotate so the line just retired drops to lowest priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_r <= '0;
    end else if (eoi && eoi_hit_s) begin
      base_r <= (eoi_idx_s == IDX_W'(NUM_IRQ - 1)) ? '0 : eoi_idx_s + IDX_W'(1);
    end else begin
      base_r <= base_r;
    end
  end

  assign base_s = base_r;
`else
  assign base_s = '0;
`endif

  // Acknowledge FSM next state.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ACK_IDLE: state_next_s = inta ? ACK_ONE : ACK_IDLE;
      ACK_ONE:  state_next_s = inta ? ACK_TWO : ACK_ONE;
      ACK_TWO:  state_next_s = ACK_IDLE;
      default:  state_next_s = ACK_IDLE;
    endcase
  end

  // Synchroniser, edge history and the delayed edge pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= '0;
      sync2_r <= '0;
      prev_r  <= '0;
      edge_r  <= '0;
    end else begin
      sync1_r <= irq_lines;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
      edge_r  <= sync2_r & ~prev_r;
    end
  end

  // Request/service registers, FSM and registered CPU-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irr_r          <= '0;
      isr_r          <= '0;
      state_r        <= ACK_IDLE;
      latch_idx_r    <= '0;
      int_out_r      <= 1'b0;
      vector_valid_r <= 1'b0;
      vector_idx_r   <= '0;
    end else begin
      irr_r          <= irr_next_s;
      isr_r          <= isr_post_s | win_mask_s;
      state_r        <= state_next_s;
      int_out_r      <= (state_next_s == ACK_IDLE) && win_valid_s;
      vector_valid_r <= (state_r == ACK_ONE) && inta;
      if (take_s) begin
        latch_idx_r <= win_valid_s ? win_idx_s : SPURIOUS_IDX;
      end
      if ((state_r == ACK_ONE) && inta) begin
        vector_idx_r <= latch_idx_r;
      end
    end
  end

  assign int_out      = int_out_r;
  assign vector_idx   = vector_idx_r;
  assign vector_valid = vector_valid_r;
  assign irr          = irr_r;
  assign isr          = isr_r;

endmodule
